// File: rtl/bicubic_pkg.sv
// Shared sizing constants and types for the bicubic neighbourhood fetch controller.
package bicubic_pkg;

  localparam int DIM_W     = 10;
  localparam int ADDR_W    = 17;
  localparam int FRAC_W    = 8;
  localparam int NUM_BANKS = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE,
    DONE
  } state_t;

  typedef logic [1:0] tap_row_t;
  typedef logic [1:0] tap_bank_t;

endpackage

// File: rtl/bicubic_fetch_ctrl_addr_gen.sv
// Maps one row of the 4x4 bicubic neighbourhood onto the four column-interleaved banks.
module bicubic_tap_addr_gen
  import bicubic_pkg::*;
(
  input  logic [DIM_W-1:0]            sx,
  input  logic [DIM_W-1:0]            sy,
  input  logic [1:0]                  tap_row,
  input  logic [DIM_W-1:0]            rows,
  input  logic [DIM_W-1:0]            cols,
  input  logic [DIM_W-1:0]            wpr,
  output logic [NUM_BANKS-1:0]        rd_en,
  output logic [NUM_BANKS*ADDR_W-1:0] rd_addr,
  output logic [2*NUM_BANKS-1:0]      tap_bank
);

  logic [DIM_W-1:0]  rows_m1;
  logic [DIM_W-1:0]  cols_m1;
  logic [DIM_W:0]    y_raw;
  logic [DIM_W:0]    c_raw;
  logic [DIM_W-1:0]  yr;
  logic [DIM_W-1:0]  ct;
  logic [ADDR_W-1:0] row_base;
  tap_bank_t         bank;

  assign rows_m1 = rows - DIM_W'(1);
  assign cols_m1 = cols - DIM_W'(1);

  // Edge taps clamp to the border, so several taps may share one bank; they then share its address too.
  always_comb begin
    rd_en    = '0;
    rd_addr  = '0;
    tap_bank = '0;
    c_raw    = '0;
    ct       = '0;
    bank     = '0;

    if (tap_row == 2'd0 && sy == '0) y_raw = '0;
    else y_raw = {1'b0, sy} + (DIM_W+1)'(tap_row) - (DIM_W+1)'(1);
    yr = (y_raw > {1'b0, rows_m1}) ? rows_m1 : y_raw[DIM_W-1:0];
    row_base = ADDR_W'(yr) * ADDR_W'(wpr);

    for (int t = 0; t < NUM_BANKS; t++) begin
      if (t == 0 && sx == '0) c_raw = '0;
      else c_raw = {1'b0, sx} + (DIM_W+1)'(t) - (DIM_W+1)'(1);
      ct   = (c_raw > {1'b0, cols_m1}) ? cols_m1 : c_raw[DIM_W-1:0];
      bank = ct[1:0];
      tap_bank[2*t +: 2] = bank;
      rd_en[bank] = 1'b1;
      rd_addr[int'(bank)*ADDR_W +: ADDR_W] = row_base + ADDR_W'(ct[DIM_W-1:2]);
    end
  end

endmodule

// File: rtl/bicubic_fetch_ctrl.sv
// Walks every output pixel of a scaled frame and issues the four row reads of its
// 4x4 source neighbourhood, one row per handshake.
module bicubic_fetch_ctrl
  import bicubic_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DIM_W-1:0]            rows,
  input  logic [DIM_W-1:0]            cols,
  input  logic [DIM_W-1:0]            out_rows,
  input  logic [DIM_W-1:0]            out_cols,
  input  logic [15:0]                 x_ratio,
  input  logic [15:0]                 y_ratio,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [NUM_BANKS-1:0]        rd_en,
  output logic [NUM_BANKS*ADDR_W-1:0] rd_addr,
  output logic [2*NUM_BANKS-1:0]      tap_bank,
  output logic [1:0]                  tap_row,
  output logic [FRAC_W-1:0]           frac_x,
  output logic [FRAC_W-1:0]           frac_y,
  output logic                        last_pixel,
  output logic                        busy,
  output logic                        done
);

  state_t            state;
  tap_row_t          tap_row_q;
  logic [DIM_W-1:0]  rows_q, cols_q, out_rows_q, out_cols_q;
  logic [15:0]       x_ratio_q, y_ratio_q;
  logic [DIM_W-1:0]  i_q, j_q, sx_q, sy_q;
  logic              last_q;

  logic [25:0]                 px, py;
  logic [DIM_W-1:0]            sx_clamp, sy_clamp, wpr;
  logic [DIM_W:0]              wpr_sum;
  logic                        last_col, last_row;
  logic [NUM_BANKS-1:0]        gen_en;
  logic [NUM_BANKS*ADDR_W-1:0] gen_addr;
  logic [2*NUM_BANKS-1:0]      gen_bank;

  assign px = 26'(j_q) * 26'(x_ratio_q);
  assign py = 26'(i_q) * 26'(y_ratio_q);
  assign sx_clamp = (px[25:8] > 18'(cols_q - DIM_W'(1))) ? cols_q - DIM_W'(1) : px[DIM_W+7:8];
  assign sy_clamp = (py[25:8] > 18'(rows_q - DIM_W'(1))) ? rows_q - DIM_W'(1) : py[DIM_W+7:8];
  assign wpr_sum  = {1'b0, cols_q} + (DIM_W+1)'(3);
  assign wpr      = {1'b0, wpr_sum[DIM_W:2]};
  assign last_col = (j_q == out_cols_q - DIM_W'(1));
  assign last_row = (i_q == out_rows_q - DIM_W'(1));

  bicubic_tap_addr_gen u_addr_gen (
    .sx       (sx_q),
    .sy       (sy_q),
    .tap_row  (tap_row_q),
    .rows     (rows_q),
    .cols     (cols_q),
    .wpr      (wpr),
    .rd_en    (gen_en),
    .rd_addr  (gen_addr),
    .tap_bank (gen_bank)
  );

  // Bank-facing outputs are only meaningful while a request is offered; force them quiet otherwise.
  assign rd_en      = rd_valid ? gen_en   : '0;
  assign rd_addr    = rd_valid ? gen_addr : '0;
  assign tap_bank   = rd_valid ? gen_bank : '0;
  assign tap_row    = tap_row_q;
  assign last_pixel = rd_valid & last_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tap_row_q  <= '0;
      i_q        <= '0;
      j_q        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
      x_ratio_q  <= '0;
      y_ratio_q  <= '0;
      last_q     <= 1'b0;
      rd_valid   <= 1'b0;
      frac_x     <= '0;
      frac_y     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rows_q     <= rows;
            cols_q     <= cols;
            out_rows_q <= out_rows;
            out_cols_q <= out_cols;
            x_ratio_q  <= x_ratio;
            y_ratio_q  <= y_ratio;
            i_q        <= '0;
            j_q        <= '0;
            busy       <= 1'b1;
            if (rows == '0 || cols == '0 || out_rows == '0 || out_cols == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          sx_q      <= sx_clamp;
          sy_q      <= sy_clamp;
          frac_x    <= px[FRAC_W-1:0];
          frac_y    <= py[FRAC_W-1:0];
          last_q    <= last_row && last_col;
          tap_row_q <= '0;
          rd_valid  <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (rd_ready) begin
            if (tap_row_q == 2'd3) begin
              rd_valid  <= 1'b0;
              tap_row_q <= '0;
              if (last_q) begin
                i_q   <= '0;
                j_q   <= '0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                if (last_col) begin
                  j_q <= '0;
                  i_q <= i_q + DIM_W'(1);
                end else begin
                  j_q <= j_q + DIM_W'(1);
                end
                state <= CALC;
              end
            end else begin
              tap_row_q <= tap_row_q + 2'd1;
            end
          end
        end
        DONE: begin
          done   <= 1'b0;
          busy   <= 1'b0;
          frac_x <= '0;
          frac_y <= '0;
          last_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_fetch_ctrl.sv
// Randomised frame walks of bicubic_fetch_ctrl checked against an arithmetic neighbourhood model.
module tb_bicubic_fetch_ctrl;
  import bicubic_pkg::*;

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        start;
  logic [DIM_W-1:0]            rows, cols, out_rows, out_cols;
  logic [15:0]                 x_ratio, y_ratio;
  logic                        rd_valid;
  logic                        rd_ready;
  logic [NUM_BANKS-1:0]        rd_en;
  logic [NUM_BANKS*ADDR_W-1:0] rd_addr;
  logic [2*NUM_BANKS-1:0]      tap_bank;
  logic [1:0]                  tap_row;
  logic [FRAC_W-1:0]           frac_x, frac_y;
  logic                        last_pixel, busy, done;

  int num_checks = 0;
  int num_fails  = 0;

  always #5 clock = ~clock;

  bicubic_fetch_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .rows       (rows),
    .cols       (cols),
    .out_rows   (out_rows),
    .out_cols   (out_cols),
    .x_ratio    (x_ratio),
    .y_ratio    (y_ratio),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .tap_bank   (tap_bank),
    .tap_row    (tap_row),
    .frac_x     (frac_x),
    .frac_y     (frac_y),
    .last_pixel (last_pixel),
    .busy       (busy),
    .done       (done)
  );

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput(tag, {rd_valid, rd_en, rd_addr, tap_bank, tap_row, frac_x, frac_y,
                      last_pixel, busy, done}, '0);
  endtask

  // Straight from the bank mapping rules: positions, clamping and address per tap.
  function automatic void modelTap(input int r, input int c, input int orr, input int oc,
                                   input int xr, input int yrat, input int i, input int j,
                                   input int tr, output logic [3:0] en, output logic [67:0] addr,
                                   output logic [7:0] banks, output logic [7:0] fx,
                                   output logic [7:0] fy, output logic last);
    int px, py, sx, sy, wpr, yrow, col, b;
    px = j * xr;
    py = i * yrat;
    sx = px / 256;
    sy = py / 256;
    if (sx > c - 1) sx = c - 1;
    if (sy > r - 1) sy = r - 1;
    fx = 8'(px % 256);
    fy = 8'(py % 256);
    wpr = (c + 3) / 4;
    yrow = sy - 1 + tr;
    if (yrow < 0) yrow = 0;
    if (yrow > r - 1) yrow = r - 1;
    en = '0;
    addr = '0;
    banks = '0;
    for (int t = 0; t < 4; t++) begin
      col = sx - 1 + t;
      if (col < 0) col = 0;
      if (col > c - 1) col = c - 1;
      b = col % 4;
      banks[2*t +: 2] = 2'(b);
      en[b] = 1'b1;
      addr[b*17 +: 17] = 17'(yrow * wpr + col / 4);
    end
    last = (i == orr - 1) && (j == oc - 1);
  endfunction

  task automatic applyStimulus(input int r, input int c, input int orr, input int oc,
                               input int xr, input int yrat);
    rows     = DIM_W'(r);
    cols     = DIM_W'(c);
    out_rows = DIM_W'(orr);
    out_cols = DIM_W'(oc);
    x_ratio  = 16'(xr);
    y_ratio  = 16'(yrat);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    // Scramble the frame inputs so only the latched copy can be in use.
    rows     = DIM_W'($urandom);
    cols     = DIM_W'($urandom);
    out_rows = DIM_W'($urandom);
    out_cols = DIM_W'($urandom);
    x_ratio  = 16'($urandom);
    y_ratio  = 16'($urandom);
  endtask

  task automatic checkRequest(input string tag, input logic [3:0] en, input logic [67:0] addr,
                              input logic [7:0] banks, input int tr, input logic [7:0] fx,
                              input logic [7:0] fy, input logic last);
    checkOutput({tag, "_rd_en"}, rd_en, en);
    checkOutput({tag, "_rd_addr"}, rd_addr, addr);
    checkOutput({tag, "_tap_bank"}, tap_bank, banks);
    checkOutput({tag, "_tap_row"}, tap_row, tr);
    checkOutput({tag, "_frac"}, {frac_x, frac_y}, {fx, fy});
    checkOutput({tag, "_last"}, last_pixel, last);
    checkOutput({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic runFrame(input int r, input int c, input int orr, input int oc, input int xr,
                          input int yrat, input int stall_pct, input int abort_at);
    logic [3:0]  en;
    logic [67:0] addr;
    logic [7:0]  banks, fx, fy;
    logic        last;
    int waits, n, hs;
    hs = 0;
    applyStimulus(r, c, orr, oc, xr, yrat);
    for (int i = 0; i < orr; i++) begin
      for (int j = 0; j < oc; j++) begin
        for (int tr = 0; tr < 4; tr++) begin
          waits = 0;
          while (!rd_valid && waits < 8) begin
            tick();
            waits++;
          end
          checkOutput("req_valid", rd_valid, 1'b1);
          if (!rd_valid) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            return;
          end
          checkOutput("issue_gap", waits, (tr == 0) ? 1 : 0);
          modelTap(r, c, orr, oc, xr, yrat, i, j, tr, en, addr, banks, fx, fy, last);
          checkRequest("req", en, addr, banks, tr, fx, fy, last);
          if (int'($urandom_range(99)) < stall_pct) begin
            n = (stall_pct >= 100) ? 3 : int'($urandom_range(3, 1));
            rd_ready = 1'b0;
            repeat (n) begin
              tick();
              checkOutput("stall_valid", rd_valid, 1'b1);
              checkRequest("stall", en, addr, banks, tr, fx, fy, last);
            end
          end
          if (hs == abort_at) begin
            reset = 1'b1;
            tick();
            checkIdle("abort_in_reset");
            reset = 1'b0;
            tick();
            checkIdle("abort_after_reset");
            repeat (4) begin
              tick();
              checkOutput("abort_no_done", {done, busy}, 2'b00);
            end
            return;
          end
          rd_ready = 1'b1;
          start    = 1'($urandom_range(1));
          tick();
          rd_ready = 1'b0;
          start    = 1'b0;
          hs++;
        end
      end
    end
    checkOutput("handshakes", hs, orr * oc * 4);
    checkOutput("done_pulse", {done, busy, rd_valid}, 3'b110);
    tick();
    checkIdle("after_done");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rd_ready = 1'b0;
    rows     = '0;
    cols     = '0;
    out_rows = '0;
    out_cols = '0;
    x_ratio  = '0;
    y_ratio  = '0;
    tick();
    tick();
    checkIdle("reset");
    reset = 1'b0;
    tick();
    checkIdle("idle");

    runFrame(100, 100, 2, 2, 'h0100, 'h0100, 0, -1);
    runFrame(100, 100, 2, 2, 'h0180, 'h0180, 0, -1);
    runFrame(100, 100, 1, 2, 'h6300, 'h0100, 100, -1);
    runFrame(7, 9, 2, 3, 'h0280, 'h0300, 40, -1);

    for (int k = 0; k < 8; k++) begin
      runFrame(int'($urandom_range(20, 1)), int'($urandom_range(20, 1)),
               int'($urandom_range(4, 1)), int'($urandom_range(4, 1)),
               int'($urandom_range(16'h0400)), int'($urandom_range(16'h0400)), 30, -1);
    end

    runFrame(20, 20, 3, 3, 'h0100, 'h0100, 0, 6);
    runFrame(12, 13, 2, 2, 'h0140, 'h01c0, 25, -1);

    applyStimulus(10, 10, 2, 0, 'h0100, 'h0100);
    checkOutput("zero_dim_done", {done, busy, rd_valid}, 3'b110);
    tick();
    checkIdle("zero_dim_idle");
    tick();
    checkIdle("zero_dim_quiet");

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/bicubic_fetch_ctrl.md
BICUBIC_FETCH_CTRL -- requirements
Module: bicubic_fetch_ctrl

Interface
REQ-001 Parameters: DIM_W=10, image dimension width; ADDR_W=17, bank word-address width; FRAC_W=8, fractional bits of the Q8.8 ratio.
REQ-002 Ports (name  direction  width  meaning):
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- rows, cols  in  DIM_W  source image size, latched on accepted start
- out_rows, out_cols  in  DIM_W  output image size, latched on accepted start
- x_ratio, y_ratio  in  16  Q8.8 source step per output pixel, latched on accepted start
- rd_valid  out  1  read-request valid
- rd_ready  in  1  downstream accepts the request
- rd_en  out  4  per-bank read enable
- rd_addr  out  4xADDR_W  per-bank word address
- tap_bank  out  4x2  bank that supplies tap t (t=0..3, columns x-1..x+2)
- tap_row  out  2  neighbourhood row index 0..3 (rows y-1..y+2)
- frac_x, frac_y  out  FRAC_W  fractional source position of the current output pixel
- last_pixel  out  1  the current request belongs to the final output pixel
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at frame end

Function
REQ-003 Bank mapping: source pixel (r,c) SHALL reside in bank c mod 4 at word address r*wpr + (c>>2), where wpr=(cols+3)>>2.
REQ-004 For output pixel (i,j): px=j*x_ratio and py=i*y_ratio, each 26 bits; sx=px>>8, sy=py>>8; frac_x=px[7:0], frac_y=py[7:0].
REQ-005 sx SHALL be clamped to cols-1 and sy to rows-1 before neighbourhood generation.
REQ-006 Tap column ct=clamp(sx-1+t, 0, cols-1); tap row yr=clamp(sy-1+tap_row, 0, rows-1).
REQ-007 tap_bank[t]=ct mod 4.
REQ-008 For each bank b used by any tap: rd_en[b]=1 and rd_addr[b]=yr*wpr+(ct>>2).
REQ-009 Unused banks SHALL drive rd_en[b]=0 and rd_addr[b]=0.
REQ-010 FSM states: IDLE, CALC, ISSUE, DONE.
REQ-011 IDLE -> CALC on start. If any latched dimension is 0, the FSM SHALL go IDLE -> DONE instead.
REQ-012 CALC lasts exactly 1 cycle, registers sx, sy and fracs, then -> ISSUE with tap_row=0.
REQ-013 ISSUE holds rd_valid=1. Each cycle with rd_valid&&rd_ready advances tap_row.
REQ-014 After the handshake on tap_row=3, the FSM advances j, wrapping to 0 with i+1. It then -> CALC, or -> DONE after pixel (out_rows-1, out_cols-1).
REQ-015 While rd_valid=1 and rd_ready=0, all rd_*, tap_*, frac_* and last_pixel outputs SHALL hold stable.
REQ-016 DONE asserts done for one cycle, then -> IDLE. start is ignored outside IDLE.
REQ-017 Throughput: 5 cycles per output pixel with rd_ready held high. The first rd_valid appears 2 cycles after start is sampled.
REQ-018 Frame sizes with rows*wpr > 2^17 are unsupported and the result is undefined.

Reset
REQ-019 reset SHALL force IDLE and clear i, j and tap_row.
REQ-020 During reset and in IDLE, every output SHALL be 0: rd_valid, rd_en, rd_addr, tap_bank, tap_row, frac_x, frac_y, last_pixel, busy and done.
REQ-021 Reset asserted mid-frame aborts the frame without asserting done. The next start begins a fresh frame.

Structure
REQ-022 Package bicubic_pkg SHALL hold DIM_W, ADDR_W, FRAC_W, NUM_BANKS=4, the FSM state enum and the tap-row/tap-bank typedefs.
REQ-023 One sub-module, bicubic_tap_addr_gen, SHALL be combinational: (sx, sy, tap_row, rows, cols, wpr) -> rd_en, rd_addr, tap_bank.

Verification
REQ-024 rows=cols=100, ratios 0x0100, out 100x100, pixel (0,0), tap_row=0 -> tap_bank={0,0,1,2}, rd_en=0111, rd_addr[0..2]=0. At tap_row=3 -> rd_addr=50.
REQ-025 x_ratio=y_ratio=0x0180, pixel (1,1) -> sx=sy=1, frac_x=frac_y=0x80, rd_en=1111. At tap_row=0 all rd_addr=0; at tap_row=1 all rd_addr=25.
REQ-026 cols=100, sx=99 -> columns {98,99,99,99}, tap_bank={2,3,3,3}, rd_en=1100, rd_addr[2]=rd_addr[3]=yr*25+24.
REQ-027 out 2x2, rd_ready=1 -> exactly 16 handshakes; last_pixel on the final 4; done one cycle after the 16th; busy low the cycle after done.
REQ-028 Drop rd_ready for 3 cycles mid-pixel -> outputs frozen; no tap_row skipped or repeated.
REQ-029 Assert reset mid-frame -> all outputs 0 the next cycle and no done; out_cols=0 with start -> done pulse and zero rd_valid.
